// File: rtl/prng_byte_dispenser_pkg.sv
// Shared types and constants for the PRNG byte dispenser.
// FSM encoding, word/byte widths and a byte-lane select helper.
package prng_byte_dispenser_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Byte lane idx of a word, lane 0 = least significant byte.
  function automatic logic [BYTE_W-1:0] word_byte(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        idx
  );
    return w[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/prng_word_fifo.sv
// Synchronous word FIFO with flush, async active-high reset.
// Ports: clk, rst, flush, push/din, pop/dout, full, empty, count.
module prng_word_fifo
  import prng_byte_dispenser_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only alongside a pop.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/prng_byte_dispenser.sv
// Consumes lfsr113 words: warm-up discard, repetition health test,
// word FIFO, and one-byte-per-cycle req/ack serving.
// Ports: CLK, reset, start, enable_p, prng_word/prng_valid,
// byte_req/byte_ack/byte_out, words_avail, health_err, running.
module prng_byte_dispenser
  import prng_byte_dispenser_pkg::*;
#(
  parameter  int FIFO_DEPTH   = 4,
  parameter  int WARMUP_WORDS = 4,
  parameter  int REP_LIMIT    = 3,
  localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic              enable_p,
  input  logic [WORD_W-1:0] prng_word,
  input  logic              prng_valid,
  input  logic              byte_req,
  output logic              byte_ack,
  output logic [BYTE_W-1:0] byte_out,
  output logic [CW-1:0]     words_avail,
  output logic              health_err,
  output logic              running
);

  localparam int WW = $clog2(WARMUP_WORDS + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  state_t            state_q, state_d;
  logic              enable_q, enable_d;
  logic              ack_q, ack_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [1:0]        idx_q, idx_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [WORD_W-1:0] last_q, last_d;
  logic [WW-1:0]     warm_q, warm_d;

  logic              checking, rep_fault;
  logic              serve, fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] head;

  assign enable_p   = enable_q;
  assign byte_ack   = ack_q;
  assign byte_out   = byte_q;
  assign running    = (state_q == ST_RUN);
  assign health_err = (state_q == ST_FAULT);

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    byte_d    = byte_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    last_d    = last_q;
    warm_d    = warm_q;
    rep_fault = 1'b0;

    // Health test sees every valid word while active, dropped or not.
    // last_q starts at 0, so a generator stuck at 0 also trips it.
    checking = prng_valid &&
               (state_q == ST_WARMUP || state_q == ST_RUN);
    if (checking) begin
      last_d    = prng_word;
      rep_d     = (prng_word == last_q) ? rep_q + RW'(1) : RW'(1);
      rep_fault = (rep_d == RW'(REP_LIMIT));
    end

    serve     = (state_q == ST_RUN) && byte_req &&
                !fifo_empty && !rep_fault;
    fifo_pop  = serve && (idx_q == 2'd3);
    fifo_push = (state_q == ST_RUN) && prng_valid && !rep_fault;

    if (serve) begin
      ack_d  = 1'b1;
      byte_d = word_byte(head, idx_q);
      idx_d  = idx_q + 2'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WARMUP;
          warm_d  = '0;
        end
      end
      ST_WARMUP: begin
        if (prng_valid) begin
          warm_d = warm_q + WW'(1);
          if (warm_d == WW'(WARMUP_WORDS)) state_d = ST_RUN;
        end
      end
      ST_RUN:   state_d = ST_RUN;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if (rep_fault) state_d = ST_FAULT;

    fifo_flush = (state_d == ST_FAULT);
    if (fifo_flush) idx_d = '0;

    enable_d = (state_d == ST_WARMUP) || (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      enable_q <= 1'b0;
      ack_q    <= 1'b0;
      byte_q   <= '0;
      idx_q    <= '0;
      rep_q    <= '0;
      last_q   <= '0;
      warm_q   <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      ack_q    <= ack_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      last_q   <= last_d;
      warm_q   <= warm_d;
    end
  end

  prng_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (prng_word),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (words_avail)
  );

endmodule

// File: tb/tb_prng_byte_dispenser.sv
// Self-checking bench for prng_byte_dispenser.
// Directed scenarios plus random traffic against a queue model.
module tb_prng_byte_dispenser;

  localparam int DEPTH = 4;
  localparam int WARM  = 4;
  localparam int REP   = 3;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        enable_p;
  logic [31:0] prng_word = '0;
  logic        prng_valid = 1'b0;
  logic        byte_req = 1'b0;
  logic        byte_ack;
  logic [7:0]  byte_out;
  logic [2:0]  words_avail;
  logic        health_err;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  prng_byte_dispenser #(
    .FIFO_DEPTH   (DEPTH),
    .WARMUP_WORDS (WARM),
    .REP_LIMIT    (REP)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .enable_p    (enable_p),
    .prng_word   (prng_word),
    .prng_valid  (prng_valid),
    .byte_req    (byte_req),
    .byte_ack    (byte_ack),
    .byte_out    (byte_out),
    .words_avail (words_avail),
    .health_err  (health_err),
    .running     (running)
  );

  always #5 CLK = ~CLK;

  // Reference model: mode 0 idle, 1 warm-up, 2 run, 3 fault.
  int          m;
  bit [31:0]   mq[$];
  int          bi, rep, warm;
  bit [31:0]   last;
  logic        exp_ack, exp_en, exp_run, exp_err;
  logic [7:0]  exp_byte;
  int          exp_avail;

  function automatic void model_outs();
    exp_en    = (m == 1 || m == 2);
    exp_run   = (m == 2);
    exp_err   = (m == 3);
    exp_avail = mq.size();
  endfunction

  function automatic void model_reset();
    m = 0; mq.delete(); bi = 0; rep = 0; warm = 0; last = '0;
    exp_ack = 1'b0; exp_byte = 8'h00;
    model_outs();
  endfunction

  task automatic model_step(input bit s, input bit v,
                            input bit [31:0] w, input bit r);
    bit flt = 0;
    bit popd = 0;
    int sz = mq.size();
    bit [31:0] hw;
    if ((m == 1 || m == 2) && v) begin
      rep  = (w == last) ? rep + 1 : 1;
      last = w;
      if (rep >= REP) flt = 1;
    end
    exp_ack = 1'b0;
    if (m == 2 && r && sz > 0 && !flt) begin
      hw = mq[0];
      exp_ack  = 1'b1;
      exp_byte = 8'(hw >> (8 * bi));
      bi++;
      if (bi == 4) begin
        bi = 0;
        void'(mq.pop_front());
        popd = 1;
      end
    end
    if (m == 2 && v && !flt && (sz < DEPTH || popd)) mq.push_back(w);
    if (flt) begin
      m = 3; mq.delete(); bi = 0;
    end else if (m == 0 && s) begin
      m = 1; warm = 0;
    end else if (m == 1 && v) begin
      warm++;
      if (warm == WARM) m = 2;
    end
    model_outs();
  endtask

  task automatic cycle(input bit s, input bit v,
                       input bit [31:0] w, input bit r);
    start = s; prng_valid = v; prng_word = w; byte_req = r;
    @(posedge CLK);
    model_step(s, v, w, r);
    #1;
  endtask

  function automatic bit [31:0] fresh();
    bit [31:0] w = $urandom;
    if (w == last) w = ~w;
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 0; prng_valid = 0; byte_req = 0;
    model_reset();
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  task automatic bring_up();
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < WARM; i++) cycle(0, 1, fresh(), 0);
  endtask

  task automatic test_reset();
    do_reset();
    if (enable_p !== 1'b0) begin
      n_fail++; $display("FAIL reset enable_p got %b want 0", enable_p);
    end
    n_tests++;
    if (byte_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset byte_ack got %b want 0", byte_ack);
    end
    n_tests++;
    if (byte_out !== 8'h00) begin
      n_fail++; $display("FAIL reset byte_out got %h want 00", byte_out);
    end
    n_tests++;
    if (words_avail !== 3'd0) begin
      n_fail++; $display("FAIL reset words_avail got %0d want 0", words_avail);
    end
    n_tests++;
    if (health_err !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset err/run got %b%b want 00", health_err, running);
    end
    n_tests++;
    cycle(1, 0, 0, 0);
    if (enable_p !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL start en/run got %b%b want 10", enable_p, running);
    end
    n_tests++;
  endtask

  task automatic test_nominal();
    bit [7:0] want [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    bring_up();
    if (running !== 1'b1) begin
      n_fail++; $display("FAIL nominal running got %b want 1", running);
    end
    n_tests++;
    cycle(0, 1, 32'h11223344, 0);
    if (words_avail !== 3'd1) begin
      n_fail++; $display("FAIL nominal avail got %0d want 1", words_avail);
    end
    n_tests++;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      if (byte_ack !== 1'b1 || byte_out !== want[i]) begin
        n_fail++;
        $display("FAIL nominal byte%0d got ack=%b %h want ack=1 %h",
                 i, byte_ack, byte_out, want[i]);
      end
      n_tests++;
      if (words_avail !== ((i == 3) ? 3'd0 : 3'd1)) begin
        n_fail++;
        $display("FAIL nominal avail%0d got %0d", i, words_avail);
      end
      n_tests++;
    end
    cycle(0, 0, 0, 0);
    if (byte_ack !== 1'b0 || byte_out !== 8'h11) begin
      n_fail++;
      $display("FAIL nominal hold got ack=%b %h want ack=0 11",
               byte_ack, byte_out);
    end
    n_tests++;
  endtask

  task automatic test_fault();
    bring_up();
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'hDEADBEEF, 0);
    if (health_err !== 1'b1 || enable_p !== 1'b0) begin
      n_fail++;
      $display("FAIL fault err/en got %b%b want 10", health_err, enable_p);
    end
    n_tests++;
    if (words_avail !== 3'd0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL fault avail/run got %0d/%b want 0/0",
               words_avail, running);
    end
    n_tests++;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, fresh(), 1);
      if (byte_ack !== 1'b0 || health_err !== 1'b1 || enable_p !== 1'b0) begin
        n_fail++;
        $display("FAIL fault sticky got ack=%b err=%b en=%b want 0 1 0",
                 byte_ack, health_err, enable_p);
      end
      n_tests++;
    end
  endtask

  task automatic test_warmup_boundary();
    bit [7:0] want [4] = '{8'hAA, 8'h55, 8'hAA, 8'h55};
    do_reset();
    cycle(1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 32'hAAAA0000 + 32'(i), 0);
    if (words_avail !== 3'd0 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL warmup discard got avail=%0d run=%b want 0 1",
               words_avail, running);
    end
    n_tests++;
    cycle(0, 1, 32'h55AA55AA, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      if (byte_ack !== 1'b1 || byte_out !== want[i]) begin
        n_fail++;
        $display("FAIL warmup byte%0d got ack=%b %h want %h",
                 i, byte_ack, byte_out, want[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_full();
    bit [31:0] w [6];
    bit [31:0] x [4];
    bit [31:0] y;
    bit [7:0]  wb;
    bring_up();
    for (int i = 0; i < 6; i++) begin
      w[i] = fresh();
      cycle(0, 1, w[i], 0);
    end
    if (words_avail !== 3'd4) begin
      n_fail++; $display("FAIL full avail got %0d want 4", words_avail);
    end
    n_tests++;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1);
      wb = 8'(w[i / 4] >> (8 * (i % 4)));
      if (byte_ack !== 1'b1 || byte_out !== wb) begin
        n_fail++;
        $display("FAIL full byte%0d got ack=%b %h want %h",
                 i, byte_ack, byte_out, wb);
      end
      n_tests++;
    end
    for (int i = 0; i < 4; i++) begin
      x[i] = fresh();
      cycle(0, 1, x[i], 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    y = fresh();
    cycle(0, 1, y, 1);
    if (words_avail !== 3'd4 || byte_out !== x[0][31:24]) begin
      n_fail++;
      $display("FAIL full pushpop got avail=%0d %h want 4 %h",
               words_avail, byte_out, x[0][31:24]);
    end
    n_tests++;
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1);
      wb = (i < 12) ? 8'(x[1 + i / 4] >> (8 * (i % 4)))
                    : 8'(y >> (8 * (i % 4)));
      if (byte_ack !== 1'b1 || byte_out !== wb) begin
        n_fail++;
        $display("FAIL full drain%0d got %h want %h", i, byte_out, wb);
      end
      n_tests++;
    end
  endtask

  task automatic test_empty_stall();
    bit [31:0] w;
    bring_up();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1);
      if (byte_ack !== 1'b0) begin
        n_fail++; $display("FAIL stall ack%0d got %b want 0", i, byte_ack);
      end
      n_tests++;
    end
    w = fresh();
    cycle(0, 1, w, 1);
    if (byte_ack !== 1'b0 || words_avail !== 3'd1) begin
      n_fail++;
      $display("FAIL stall arrive got ack=%b avail=%0d want 0 1",
               byte_ack, words_avail);
    end
    n_tests++;
    cycle(0, 0, 0, 1);
    if (byte_ack !== 1'b1 || byte_out !== w[7:0]) begin
      n_fail++;
      $display("FAIL stall serve got ack=%b %h want 1 %h",
               byte_ack, byte_out, w[7:0]);
    end
    n_tests++;
  endtask

  task automatic test_async_reset();
    bring_up();
    cycle(0, 1, fresh(), 0);
    cycle(0, 1, fresh(), 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    if ({enable_p, byte_ack, health_err, running} !== 4'b0000 ||
        byte_out !== 8'h00 || words_avail !== 3'd0) begin
      n_fail++;
      $display("FAIL async got en=%b ack=%b err=%b run=%b %h avail=%0d",
               enable_p, byte_ack, health_err, running, byte_out,
               words_avail);
    end
    n_tests++;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, fresh(), 1);
      if (enable_p !== 1'b0 || running !== 1'b0 || words_avail !== 3'd0) begin
        n_fail++;
        $display("FAIL async idle got en=%b run=%b avail=%0d",
                 enable_p, running, words_avail);
      end
      n_tests++;
    end
    cycle(1, 0, 0, 0);
    if (enable_p !== 1'b1) begin
      n_fail++; $display("FAIL async restart en got %b want 1", enable_p);
    end
    n_tests++;
  endtask

  task automatic test_random();
    bit        s, v, r;
    bit [31:0] w;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      s = ($urandom_range(0, 7) == 0);
      v = $urandom_range(0, 1) == 1;
      r = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 9) == 0) ? last : $urandom;
      cycle(s, v, w, r);
      if (byte_ack !== exp_ack) begin
        n_fail++;
        $display("FAIL rand%0d ack got %b want %b", i, byte_ack, exp_ack);
      end
      n_tests++;
      if (byte_out !== exp_byte) begin
        n_fail++;
        $display("FAIL rand%0d byte got %h want %h", i, byte_out, exp_byte);
      end
      n_tests++;
      if (words_avail !== 3'(exp_avail)) begin
        n_fail++;
        $display("FAIL rand%0d avail got %0d want %0d",
                 i, words_avail, exp_avail);
      end
      n_tests++;
      if ({enable_p, running, health_err} !== {exp_en, exp_run, exp_err}) begin
        n_fail++;
        $display("FAIL rand%0d en/run/err got %b%b%b want %b%b%b", i,
                 enable_p, running, health_err, exp_en, exp_run, exp_err);
      end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fault();
    test_warmup_boundary();
    test_full();
    test_empty_stall();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
